alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 alu_control  input  3  operation code (see REQ-012).
REQ-007 src_a  input  WIDTH  operand A.
REQ-008 src_b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  result entry presented at head of output buffer.
REQ-010 out_ready  input  1  downstream consumes head entry this cycle.
REQ-011 result / zero / illegal  output  WIDTH / 1 / 1  head entry's result, result==0 flag, illegal-opcode flag.

Function
REQ-012 Opcodes SHALL be: 000 add, 001 sub (A-B), 010 AND, 011 OR, 101 signed set-less-than; 100, 110, 111 illegal.
REQ-013 add/sub SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-014 slt SHALL yield 1 when signed(A) < signed(B), else 0, correct under subtraction overflow (e.g. A=0x80000000, B=1 -> 1).
REQ-015 Illegal opcode SHALL yield result=0, illegal=1, zero=1; still consumes a buffer slot and is delivered in order.
REQ-016 zero SHALL equal (result==0) for every delivered entry.
REQ-017 Accept occurs on a rising edge where in_valid & in_ready; operands and opcode sampled at that edge only.
REQ-018 Result computed combinationally from sampled inputs and written into a 2-entry in-order output buffer at the accepting edge.
REQ-019 Latency: entry accepted at edge N SHALL appear (if buffer was empty, or head popped at N) with out_valid=1 in the cycle following edge N; never same-cycle.
REQ-020 Occupancy counter states EMPTY(0), ONE(1), FULL(2); out_valid = (count!=0); in_ready = !reset & (count!=2).
REQ-021 Pop occurs on a rising edge where out_valid & out_ready; head advances to next-oldest entry.
REQ-022 Transitions: accept only -> count+1; pop only -> count-1; accept and pop in ONE -> stays ONE, new entry becomes head; FULL never accepts.
REQ-023 in_ready SHALL depend only on registered count and reset, never combinationally on out_ready.
REQ-024 While out_valid=1 and out_ready=0, result/zero/illegal SHALL hold stable.
REQ-025 When out_valid=0, result, zero and illegal SHALL be driven 0.
REQ-026 in_valid while in_ready=0 SHALL be ignored; no state change, no data capture.
REQ-027 out_ready while out_valid=0 SHALL be ignored.
REQ-028 Sustained throughput with in_valid=out_ready=1 SHALL be one operation per cycle.

Reset
REQ-029 On reset assertion: count=EMPTY, out_valid=0, result=0, zero=0, illegal=0, in_ready=0, asynchronously.
REQ-030 Reset mid-operation SHALL discard all buffered entries; none delivered after release.
REQ-031 First rising edge after reset release SHALL accept an operation if in_valid=1 (in_ready=1 immediately on release).

Verification
REQ-032 Ops sweep, out_ready=1: (000,5,3)->8; (001,3,5)->0xFFFFFFFE; (010,0xF0,0x3C)->0x30; (011,0xF0,0x0F)->0xFF; (101,0xFFFFFFFF,1)->1, each one cycle after accept.
REQ-033 Zero/illegal: (001,7,7)->result 0, zero=1, illegal=0; (110,1,2)->result 0, zero=1, illegal=1.
REQ-034 Backpressure: out_ready=0, three back-to-back ops -> first two accepted, in_ready=0 at third, head held stable; raise out_ready -> results in order, third accepted only after first pop.
REQ-035 Simultaneous accept+pop in ONE: count stays 1, next head equals newly accepted result, no loss or duplication over 100 random ops vs. reference model.
REQ-036 Async reset asserted mid-cycle with FULL buffer -> out_valid=0, in_ready=0 without clock edge; after release, no stale entries appear.

Source files
------------

// File: rtl/alu_exec.sv
// Single-issue ALU with a 2-entry in-order result buffer and valid/ready handshakes.
// The result is computed from the accepting-edge operands and is registered, so a result never appears in the same cycle it is accepted.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

  cnt_e   count, count_nxt;
  entry_t slot0, slot1, new_e;
  logic   acc, pop;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_comb begin
    new_e = '0;
    case (alu_control)
      3'b000:  new_e.res = src_a + src_b;
      3'b001:  new_e.res = src_a - src_b;
      3'b010:  new_e.res = src_a & src_b;
      3'b011:  new_e.res = src_a | src_b;
      // signed compare directly, so A-B overflow cannot flip the answer
      3'b101:  new_e.res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: new_e.illegal = 1'b1;
    endcase
    new_e.zero = (new_e.res == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= EMPTY;
    else       count <= count_nxt;
  end

  always_comb begin
    count_nxt = count;
    case (count)
      EMPTY:   if (acc) count_nxt = ONE;
      ONE:     if (acc && !pop) count_nxt = FULL;
               else if (!acc && pop) count_nxt = EMPTY;
      FULL:    if (pop) count_nxt = ONE;
      default: count_nxt = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = !reset && (count != FULL);
    out_valid = (count != EMPTY);
    result    = out_valid ? slot0.res     : '0;
    zero      = out_valid ? slot0.zero    : 1'b0;
    illegal   = out_valid ? slot0.illegal : 1'b0;
  end

  // slot0 is always the head; slot1 only holds data while FULL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (pop) begin
      if (count == FULL) slot0 <= slot1;
      else if (acc)      slot0 <= new_e;
    end else if (acc) begin
      if (count == EMPTY) slot0 <= new_e;
      else                slot1 <= new_e;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected entries queued at accept, compared at pop.
module tb_alu_exec;
  localparam int W = 32;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a, src_b, result;

  int n_chk = 0, n_fail = 0, n_acc = 0;
  logic [W+1:0] q[$];

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: {result, zero, illegal}
  function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         ill;
    r = '0; ill = 1'b0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (($signed(a) < $signed(b)) ? 1 : 0);
      default: ill = 1'b1;
    endcase
    return {r, (r == '0), ill};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        chk("zero_flag", {63'd0, zero}, {63'd0, (result == '0)});
        if (out_ready) begin
          if (q.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
          else chk("sb_data", {30'd0, result, zero, illegal}, {30'd0, q.pop_front()});
        end
      end else begin
        chk("idle_outputs", {30'd0, result, zero, illegal}, 64'd0);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(alu_control, src_a, src_b));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic sweep(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input logic ei);
    send(op, a, b);
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_data", {30'd0, result, zero, illegal}, {30'd0, er, ez, ei});
  endtask

  initial begin
    int start;
    logic [W-1:0] head;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; src_a = '0; src_b = '0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out", {29'd0, out_valid, result, zero, illegal}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;

    sweep(3'b000, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    sweep(3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    sweep(3'b010, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
    sweep(3'b011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
    sweep(3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    sweep(3'b101, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);
    sweep(3'b101, 32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    sweep(3'b001, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    sweep(3'b110, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);
    sweep(3'b100, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
    @(posedge clk); #1;

    // backpressure: two fill the buffer, the third must wait for a pop
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd2);
    send(3'b010, 32'hFF, 32'h0F);
    in_valid = 1'b1; alu_control = 3'b011; src_a = 32'd1; src_b = 32'd2;
    @(negedge clk);
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    head = result;
    chk("bp_head", {32'd0, head}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {32'd0, result}, {32'd0, head});
      chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_acc_at_pop", {63'd0, in_ready}, 64'd0);
    send(3'b011, 32'd1, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", q.size(), 64'd0);

    // sustained throughput, accept+pop in ONE every cycle
    start = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      alu_control = 3'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("throughput", n_acc - start, 64'd10);
    repeat (2) @(posedge clk);
    #1;

    // random traffic with random backpressure
    start = n_acc;
    for (int i = 0; i < 2000 && (n_acc - start) < 100; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 1) != 0);
      alu_control = 3'($urandom_range(0, 7));
      src_a = ($urandom_range(0, 3) == 0) ? src_b : $urandom;
      src_b = $urandom;
      @(posedge clk); #1;
    end
    chk("rand_count", (n_acc - start) >= 100, 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drained", q.size(), 64'd0);

    // async reset with a full buffer
    out_ready = 1'b0;
    send(3'b001, 32'd5, 32'd5);
    send(3'b000, 32'd10, 32'd20);
    #1;
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("arst_data", {30'd0, result, zero, illegal}, 64'd0);
    q.delete();
    #1;
    reset = 1'b0;
    #1;
    chk("arel_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", {63'd0, out_valid}, 64'd0);
    end
    sweep(3'b000, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("final_empty", q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
